serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Digit-serial subtractor that computes the full-precision difference of two WIDTH-bit unsigned operands over several clock cycles, trading latency for a narrow datapath. It is the inverse-operation companion to the registered wide adder in the arithmetic benchmark set, and it exercises carry/borrow-chain mapping with real control sequencing. Operands enter and results leave through valid/ready handshakes, so the block can sit between a stimulus source and a result sink.

## Interface
- WIDTH, 65, operand width in bits.
- DIGIT, 8, bits processed per cycle; N = ceil(WIDTH/DIGIT) digit cycles per operation (9 at defaults).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair on a/b is valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- out_valid  output  1  diff holds a completed result.
- out_ready  input  1  sink accepts diff.
- diff  output  WIDTH+1  result {0,a} - {0,b} in WIDTH+1 bits; diff[WIDTH] = final borrow (1 iff a < b).
- One clock; the reset is asynchronous and active-low.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1 and out_valid = 0.
  - On a clock edge with in_valid = 1, the block captures a and b into shift registers, clears the borrow and the digit counter, and moves to RUN.
- RUN:
  - in_ready = 0.
  - Each edge subtracts the low DIGIT bits of the a/b shift registers minus the borrow, giving DIGIT result bits plus a borrow-out.
  - The result bits shift into the result register from the top. The operand registers shift right by DIGIT with zero fill, and the counter increments.
  - On the edge where counter = N-1, the block loads diff, with bit WIDTH taken from the final borrow, and moves to DONE.
- Padding:
  - Bits above WIDTH-1 in the last digit are zero-padded.
  - When WIDTH mod DIGIT ≠ 0, the final borrow is the borrow out of bit WIDTH-1, not out of the padded digit top.
- DONE:
  - out_valid = 1, and diff is held stable.
  - On an edge with out_ready = 1, the block moves to IDLE.
  - in_ready = 0; a new operand is never accepted in the same cycle as result delivery.
- in_valid is ignored outside IDLE. a and b are sampled only on the accepting edge, so changes after acceptance have no effect.
- Arithmetic:
  - diff[WIDTH-1:0] = (a - b) mod 2^WIDTH.
  - diff[WIDTH] = borrow.
  - This equals a + ~b + 1 with the carry inverted.

## Timing
- Reset values, applied immediately while rst_n = 0 and independent of clk:
  - state = IDLE, in_ready = 1, out_valid = 0, diff = 0.
  - The counter, borrow and shift registers are cleared.
- Latency: the operand is accepted at edge T, and out_valid rises after edge T+N (edge T+9 at defaults).
- out_ready is honoured in the first out_valid cycle. If out_ready = 1 at edge T+N+1, in_ready = 1 after that edge.
- Minimum spacing between successive accepts is N+2 edges.
- Backpressure: out_valid and diff are held for any number of cycles while out_ready = 0.
- Reset mid-operation, in RUN or DONE: the operation is abandoned with no result emitted, and all outputs return to their reset values.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Basic subtraction: a = 100, b = 58 accepted at edge T → out_valid after edge T+9, diff = 42, diff[65] = 0.
- Borrow/underflow: a = 0, b = 1 → diff[64:0] = all ones, diff[65] = 1. Also a = b = 2^65-1 → diff = 0.
- Digit-chain propagation:
  - a = 2^64, b = 1 → diff = 2^64-1, borrow 0; this checks borrow crossing all 9 digits, including the 1-bit last digit.
  - a = 1, b = 2^64 → diff[65] = 1.
- Backpressure and ignore:
  - Hold out_ready = 0 for 20 cycles → diff is stable and in_ready = 0 throughout.
  - Toggle in_valid and a/b during RUN → the result is unaffected.
- Reset mid-operation: assert rst_n = 0 asynchronously, with no clock edge, during cycle 4 of RUN → out_valid = 0, diff = 0, in_ready = 1 immediately. The next operation is 7 - 3 → diff = 4.
- Back-to-back random: 1000 random a/b pairs with random in_valid and out_ready duty → every diff matches {0,a} - {0,b}, results arrive in order, and none are lost or duplicated. Repeat with DIGIT = 1, 13 and 65, where N = 65, 5 and 1.

Source files
------------

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: diff = {0,a} - {0,b}, computed DIGIT bits per
// clock between a valid/ready operand port and a valid/ready result port.
module serial_subtractor #(
   parameter int WIDTH = 65,
   parameter int DIGIT = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   diff
);

   localparam int N  = (WIDTH + DIGIT - 1) / DIGIT;
   localparam int PW = N * DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_r;
   logic            in_ready_r;
   logic            out_valid_r;
   logic [WIDTH:0]  diff_r;
   logic [PW-1:0]   a_sh_r;
   logic [PW-1:0]   b_sh_r;
   logic [PW-1:0]   res_sh_r;
   logic            borrow_r;
   logic [CW-1:0]   cnt_r;

   logic [DIGIT:0]  sub_s;
   logic            borrow_out_s;
   logic [PW-1:0]   res_next_s;

   // One digit of x - y - bin; the top bit of the result is the borrow-out.
   function automatic logic [DIGIT:0] digit_sub(input logic [DIGIT-1:0] x,
                                                input logic [DIGIT-1:0] y,
                                                input logic             bin);
      digit_sub = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bin};
   endfunction

   // Current digit difference and the result register as it will look after this digit.
   always_comb begin
      sub_s        = digit_sub(a_sh_r[DIGIT-1:0], b_sh_r[DIGIT-1:0], borrow_r);
      borrow_out_s = sub_s[DIGIT];
      res_next_s   = (res_sh_r >> DIGIT) | (PW'(sub_s[DIGIT-1:0]) << (PW - DIGIT));
   end

   // Control FSM and serial datapath with registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         diff_r      <= '0;
         a_sh_r      <= '0;
         b_sh_r      <= '0;
         res_sh_r    <= '0;
         borrow_r    <= 1'b0;
         cnt_r       <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               out_valid_r <= 1'b0;
               if (in_valid) begin
                  a_sh_r     <= PW'(a);
                  b_sh_r     <= PW'(b);
                  res_sh_r   <= '0;
                  borrow_r   <= 1'b0;
                  cnt_r      <= '0;
                  in_ready_r <= 1'b0;
                  state_r    <= RUN;
               end else begin
                  in_ready_r <= 1'b1;
               end
            end
            RUN: begin
               a_sh_r   <= a_sh_r >> DIGIT;
               b_sh_r   <= b_sh_r >> DIGIT;
               res_sh_r <= res_next_s;
               borrow_r <= borrow_out_s;
               cnt_r    <= cnt_r + CW'(1);
               if (cnt_r == CW'(N - 1)) begin
                  // Padding bits are zero in both operands, so the borrow out of the
                  // padded digit top equals the borrow out of bit WIDTH-1.
                  diff_r      <= {borrow_out_s, res_next_s[WIDTH-1:0]};
                  out_valid_r <= 1'b1;
                  state_r     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= IDLE;
               end
            end
            default: begin
               state_r     <= IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign diff      = diff_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases and handshake timing
// on the default build, then randomized traffic against an arithmetic reference model.
module tb_serial_subtractor;

   localparam int W = 65;
   typedef logic [W:0] res_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, out_ready, in_ready, out_valid;
   logic [W-1:0] a, b;
   res_t         diff;

   logic         va, ra;
   logic [W-1:0] aa, ba;
   logic [2:0]   ir_a, ov_a;
   res_t         d_a [3];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(W), .DIGIT(8)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .diff(diff));
   serial_subtractor #(.WIDTH(W), .DIGIT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(ir_a[0]), .a(aa), .b(ba),
      .out_valid(ov_a[0]), .out_ready(ra), .diff(d_a[0]));
   serial_subtractor #(.WIDTH(W), .DIGIT(13)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(ir_a[1]), .a(aa), .b(ba),
      .out_valid(ov_a[1]), .out_ready(ra), .diff(d_a[1]));
   serial_subtractor #(.WIDTH(W), .DIGIT(65)) u3 (
      .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(ir_a[2]), .a(aa), .b(ba),
      .out_valid(ov_a[2]), .out_ready(ra), .diff(d_a[2]));

   task automatic check(input string tag, input res_t obs, input res_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic res_t ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
      return {1'b0, x} - {1'b0, y};
   endfunction

   function automatic logic [W-1:0] rnd();
      logic [95:0]  t;
      logic [W-1:0] one;
      one = {{(W-1){1'b0}}, 1'b1};
      t = {$urandom, $urandom, $urandom};
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return one << $urandom_range(0, W - 1);
         default: return t[W-1:0];
      endcase
   endfunction

   // One operation on u0: accept, measure latency, optional RUN disturbance and hold.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit disturb,
                         input int hold, input string tag);
      int   k;
      res_t exp;
      res_t held;
      exp = ref_diff(x, y);
      @(negedge clk);
      check({tag, "_in_ready"}, res_t'(in_ready), res_t'(1));
      in_valid = 1'b1; a = x; b = y;
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 50) begin
         if (disturb) begin
            in_valid = 1'($urandom_range(0, 1));
            a = rnd(); b = rnd();
            check({tag, "_busy"}, res_t'(in_ready), res_t'(0));
         end
         @(posedge clk); k++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check({tag, "_latency"}, res_t'(k), res_t'(9));
      check({tag, "_diff"}, diff, exp);
      check({tag, "_ready_done"}, res_t'(in_ready), res_t'(0));
      held = diff;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); @(negedge clk);
         check({tag, "_hold_valid"}, res_t'(out_valid), res_t'(1));
         check({tag, "_hold_diff"}, diff, held);
         check({tag, "_hold_ready"}, res_t'(in_ready), res_t'(0));
      end
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_drain_valid"}, res_t'(out_valid), res_t'(0));
      check({tag, "_drain_ready"}, res_t'(in_ready), res_t'(1));
   endtask

   initial begin
      res_t q[$];
      res_t exp;
      int   acc, del, cyc, k;
      int   lat [3];
      int   nlat [3];
      logic [W-1:0] one;
      nlat = '{65, 5, 1};
      one  = {{(W-1){1'b0}}, 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      va = 1'b0; ra = 1'b0; aa = '0; ba = '0;
      #12;
      check("reset_in_ready", res_t'(in_ready), res_t'(1));
      check("reset_out_valid", res_t'(out_valid), res_t'(0));
      check("reset_diff", diff, res_t'(0));
      check("reset_alt_ready", res_t'(ir_a), res_t'(7));
      @(negedge clk);
      rst_n = 1'b1;

      run_op(65'd100, 65'd58, 1'b0, 0, "basic");
      run_op(65'd0, 65'd1, 1'b0, 0, "underflow");
      run_op('1, '1, 1'b0, 0, "max_eq");
      run_op(one << 64, one, 1'b0, 0, "chain_borrow");
      run_op(one, one << 64, 1'b0, 20, "chain_under_hold");
      run_op(65'h1_2345_6789_abcd_ef01, 65'h0_fedc_ba98_7654_3210, 1'b1, 3, "disturb");

      // Asynchronous reset during the fourth RUN cycle, away from any clock edge.
      @(negedge clk);
      in_valid = 1'b1; a = 65'd5; b = 65'd2;
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); @(posedge clk); @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", res_t'(out_valid), res_t'(0));
      check("midrst_diff", diff, res_t'(0));
      check("midrst_in_ready", res_t'(in_ready), res_t'(1));
      @(negedge clk);
      rst_n = 1'b1;
      run_op(65'd7, 65'd3, 1'b0, 0, "after_reset");

      // Random traffic with random handshake duty; results must arrive in order.
      acc = 0; del = 0; cyc = 0;
      while ((acc < 1000 || q.size() > 0) && cyc < 60000) begin
         @(negedge clk);
         cyc++;
         in_valid  = (acc < 1000) && ($urandom_range(0, 3) != 0);
         a         = rnd();
         b         = rnd();
         out_ready = ($urandom_range(0, 2) != 0);
         if (in_valid && in_ready) begin
            q.push_back(ref_diff(a, b));
            acc++;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $error("FAIL rand_extra: observed=%0h expected=no result", diff);
            end else begin
               check("rand_diff", diff, q.pop_front());
               del++;
            end
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      check("rand_delivered", res_t'(del), res_t'(1000));

      // Other digit sizes, run side by side on the same operands.
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         check("alt_ready", res_t'(ir_a), res_t'(7));
         va = 1'b1; aa = rnd(); ba = rnd();
         exp = ref_diff(aa, ba);
         @(negedge clk);
         va = 1'b0;
         lat = '{-1, -1, -1};
         k = 0;
         while (ov_a != 3'b111 && k < 80) begin
            aa = rnd(); ba = rnd();
            @(posedge clk); k++;
            @(negedge clk);
            for (int j = 0; j < 3; j++) if (ov_a[j] && lat[j] < 0) lat[j] = k;
         end
         check("alt_all_valid", res_t'(ov_a), res_t'(7));
         for (int j = 0; j < 3; j++) begin
            check("alt_diff", d_a[j], exp);
            check("alt_latency", res_t'(lat[j]), res_t'(nlat[j]));
         end
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); @(negedge clk);
         end
         ra = 1'b1;
         @(posedge clk); @(negedge clk);
         ra = 1'b0;
         check("alt_drain", res_t'(ov_a), res_t'(0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
